vga_scaled_driver: RTL and testbench
====================================

Name: vga_scaled_driver

Overview:
- Parametrised successor to the fixed-mode VGA driver: generates the full VGA raster (hs, vs, blank) from one pixel clock.
- Adds a runtime pixel-replication scale (1x/2x/4x) and emits framebuffer coordinates with a request strobe ahead of the colour data.
- Delays sync and blank by a parameterised colour-fetch latency so they stay aligned with the colour returned from memory.
- Sits between the pixel-clock PLL output and the board DAC pins; upstream pixel sources (framebuffers, pattern generators) attach to its coordinate/colour interface.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FRONT, 24, horizontal front porch (clocks)
- H_SYNC, 136, horizontal sync width
- H_BACK, 144, horizontal back porch
- V_ACTIVE, 768, visible lines per frame
- V_FRONT, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width
- V_BACK, 29, vertical back porch
- HS_POL, 0, asserted level of hs (0 = active-low)
- VS_POL, 0, asserted level of vs
- COLOR_DEPTH, 8, bits per colour channel
- FETCH_LAT, 2, clocks from px_req to valid colour_in (range 0..8)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- scale_sel  in  2  0=1x, 1=2x, 2=4x, 3=reserved (treated as 1x)
- scale_cur  out  2  scale in effect for the current frame
- px_x  out  clog2(H_ACTIVE)  scaled framebuffer column
- px_y  out  clog2(V_ACTIVE)  scaled framebuffer row
- px_req  out  1  coordinate valid (raster in active area)
- frame_start  out  1  one-clock pulse at h=0, v=0 (coordinate stage)
- line_start  out  1  one-clock pulse at h=0 of every line
- vga_r_in / vga_g_in / vga_b_in  in  COLOR_DEPTH each  colour, valid FETCH_LAT clocks after px_req
- vga_r_out / vga_g_out / vga_b_out  out  COLOR_DEPTH each  DAC colour
- vga_clk  out  1  DAC clock = ~clk, so the DAC samples mid-data
- vga_blank_n  out  1  low outside the active area
- vga_sync_n  out  1  constant 0 (no sync-on-green)
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters (default 1328); V_TOTAL = sum of the V_* parameters (default 806).
- Horizontal counter h: 0..H_TOTAL-1.
  - Region order: active [0, H_ACTIVE), front, sync, back.
  - Wraps to 0 and increments v.
- Vertical counter v: 0..V_TOTAL-1, same region order; wraps to 0 after h=H_TOTAL-1 at v=V_TOTAL-1.
- Coordinate stage (registered, depends on the current h/v):
  - px_req = (h < H_ACTIVE) and (v < V_ACTIVE).
  - px_x = h >> s, px_y = v >> s, where s = 0/1/2 for 1x/2x/4x.
  - px_x/px_y hold their last value when px_req = 0.
- Scale change:
  - scale_sel is sampled only on the clock where h=H_TOTAL-1 and v=V_TOTAL-1.
  - scale_cur updates on that edge; a frame never mixes scales.
  - Reserved value 3 loads 0.
- Output stage:
  - hs, vs and active are computed at the coordinate stage.
  - They are delayed through a FETCH_LAT+1 register chain.
  - At the chain end, colour is registered from vga_*_in when delayed active = 1, else 0.
  - vga_blank_n = delayed active.
  - Total latency from px_req to DAC pins = FETCH_LAT+1 clocks; hs/vs/blank edges appear at the pins on that same clock.
- Sync levels:
  - hs = HS_POL while h is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC); otherwise ~HS_POL.
  - vs follows the same rule, using v and the V_* parameters.
- Reset (async assert, sync release):
  - h=0, v=0, scale_cur=0, delay chain cleared.
  - px_req=0, blank_n=0, colours=0, hs=~HS_POL, vs=~VS_POL.
  - First clock after release: coordinate stage presents h=0, v=0 with frame_start=1.
  - A reset mid-frame abandons the frame; no partial-frame state survives.
- Elaboration check: fatal error if FETCH_LAT > 8 or any porch/sync parameter is 0.

Decomposition:
- Shared package vga_pkg:
  - Scale enum (SCALE_1X, SCALE_2X, SCALE_4X).
  - Timing constant sets for 640x480@60, 800x600@60, 1024x768@70.
  - Function computing the shift amount from the scale enum.
- One sub-module vga_delay_line: parametrised width/depth shift register, reset to a parameter value. Used for the sync/blank alignment chain.

Test Plan:
- Defaults, scale 1x, free-run: at the pins, hs low for exactly 136 clocks starting 1048+3 clocks after line_start; line period 1328; vs low 6 lines starting at line 771; frame period 1328*806 clocks.
- scale_sel=1 applied mid-frame:
  - scale_cur stays 0 until the frame wrap, then reads 1.
  - Next frame: px_x sequence 0,0,1,1,…,511,511.
  - px_y increments every 2 lines, reaching max 383.
- scale_sel=3 → scale_cur=0 after the wrap; px_x steps by 1.
- FETCH_LAT=0 and FETCH_LAT=4, with the source driving colour = px_x[7:0] delayed by FETCH_LAT:
  - First visible pixel on VGA_R = 0, coincident with the blank_n rising edge.
  - Last visible pixel = 255 (1x, 1024 columns wrap the 8-bit value).
- rst_n pulsed low at h=500, v=300:
  - Outputs immediately at reset values (blank_n=0, hs/vs high, colours 0).
  - After release, frame_start=1 on the first clock; hs falls 1048+FETCH_LAT+1 clocks later.
- Blanking check: colour inputs held at 8'hFF for the whole frame → vga_*_out = 0 whenever vga_blank_n = 0, and 8'hFF otherwise.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: pixel-replication scale enum, standard timing sets
// and the scale helpers used by the raster driver.
package vga_pkg;

  typedef enum logic [1:0] {
    SCALE_1X = 2'd0,
    SCALE_2X = 2'd1,
    SCALE_4X = 2'd2
  } scale_e;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_front;
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned v_active;
    int unsigned v_front;
    int unsigned v_sync;
    int unsigned v_back;
  } vga_timing_t;

  localparam vga_timing_t TIMING_640X480_60  = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam vga_timing_t TIMING_800X600_60  = '{800, 40, 128, 88, 600, 1, 4, 23};
  localparam vga_timing_t TIMING_1024X768_70 = '{1024, 24, 136, 144, 768, 3, 6, 29};

  // Right-shift applied to the raster counters to get framebuffer coordinates.
  function automatic logic [1:0] scale_shift(input scale_e s);
    case (s)
      SCALE_2X: scale_shift = 2'd1;
      SCALE_4X: scale_shift = 2'd2;
      default:  scale_shift = 2'd0;
    endcase
  endfunction

  // Raw select to scale; the reserved encoding falls back to 1x.
  function automatic scale_e scale_decode(input logic [1:0] sel);
    case (sel)
      2'd1:    scale_decode = SCALE_2X;
      2'd2:    scale_decode = SCALE_4X;
      default: scale_decode = SCALE_1X;
    endcase
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that resets every stage to RESET_VAL.
// Ports: clk, rst_n (async active-low), d (WIDTH in), q (d delayed DEPTH clocks).
// DEPTH = 0 degenerates to a wire.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_regs
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end

    // NOTE: every stage is reset because its contents drive sync pins straight
    // after reset; a deep storage array would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
      end else begin
        // NOTE: non-blocking so each stage captures its neighbour's old value.
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_scaled_driver.sv
// VGA raster generator with runtime pixel replication (1x/2x/4x).
// Ports: clk/rst_n; scale_sel in, scale_cur out; px_x/px_y/px_req/frame_start/
// line_start coordinate interface; vga_*_in colour returned FETCH_LAT clocks
// after px_req; vga_*_out, vga_clk, vga_blank_n, vga_sync_n, vga_hs, vga_vs
// DAC pins, all aligned FETCH_LAT+1 clocks after the coordinate stage.
module vga_scaled_driver
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = 1024,
  parameter int H_FRONT     = 24,
  parameter int H_SYNC      = 136,
  parameter int H_BACK      = 144,
  parameter int V_ACTIVE    = 768,
  parameter int V_FRONT     = 3,
  parameter int V_SYNC      = 6,
  parameter int V_BACK      = 29,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int COLOR_DEPTH = 8,
  parameter int FETCH_LAT   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    scale_sel,
  output logic [1:0]                    scale_cur,
  output logic [$clog2(H_ACTIVE)-1:0]   px_x,
  output logic [$clog2(V_ACTIVE)-1:0]   px_y,
  output logic                          px_req,
  output logic                          frame_start,
  output logic                          line_start,
  input  logic [COLOR_DEPTH-1:0]        vga_r_in,
  input  logic [COLOR_DEPTH-1:0]        vga_g_in,
  input  logic [COLOR_DEPTH-1:0]        vga_b_in,
  output logic [COLOR_DEPTH-1:0]        vga_r_out,
  output logic [COLOR_DEPTH-1:0]        vga_g_out,
  output logic [COLOR_DEPTH-1:0]        vga_b_out,
  output logic                          vga_clk,
  output logic                          vga_blank_n,
  output logic                          vga_sync_n,
  output logic                          vga_hs,
  output logic                          vga_vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  if (FETCH_LAT < 0 || FETCH_LAT > 8 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_param_check
    $fatal(1, "vga_scaled_driver: FETCH_LAT must be 0..8 and porch/sync widths non-zero");
  end

  // Raster counters, frame scale and coordinate stage.
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  scale_e        scale_q, scale_d;
  logic [XW-1:0] px_x_q, px_x_d;
  logic [YW-1:0] px_y_q, px_y_d;
  logic          px_req_q, px_req_d;
  logic          frame_start_q, frame_start_d;
  logic          line_start_q, line_start_d;
  logic          hs_c_q, hs_c_d;
  logic          vs_c_q, vs_c_d;
  logic [1:0]    shift;
  logic          last_h, last_v, active;

  always_comb begin
    // NOTE: every output of this block gets a default first, so the px_x/px_y
    // hold below is a register feedback path rather than an inferred latch.
    h_d     = h_q + HW'(1);
    v_d     = v_q;
    scale_d = scale_q;
    px_x_d  = px_x_q;
    px_y_d  = px_y_q;
    shift   = scale_shift(scale_q);

    last_h = (h_q == H_LAST);
    last_v = (v_q == V_LAST);
    active = (h_q < H_ACT) && (v_q < V_ACT);

    if (last_h) begin
      h_d = '0;
      v_d = last_v ? '0 : v_q + VW'(1);
      // Scale changes only on the final clock of a frame so no frame mixes scales.
      if (last_v) scale_d = scale_decode(scale_sel);
    end

    if (active) begin
      px_x_d = XW'(h_q >> shift);
      px_y_d = YW'(v_q >> shift);
    end

    px_req_d      = active;
    frame_start_d = (h_q == '0) && (v_q == '0);
    line_start_d  = (h_q == '0);
    hs_c_d        = (h_q >= HS_START && h_q < HS_END) ? HS_POL : ~HS_POL;
    vs_c_d        = (v_q >= VS_START && v_q < VS_END) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      scale_q       <= SCALE_1X;
      px_x_q        <= '0;
      px_y_q        <= '0;
      px_req_q      <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      hs_c_q        <= ~HS_POL;
      vs_c_q        <= ~VS_POL;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      scale_q       <= scale_d;
      px_x_q        <= px_x_d;
      px_y_q        <= px_y_d;
      px_req_q      <= px_req_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      hs_c_q        <= hs_c_d;
      vs_c_q        <= vs_c_d;
    end
  end

  // FETCH_LAT stages here plus the pin register below give FETCH_LAT+1 total,
  // so delayed active lines up with colour arriving from the fetch path.
  logic [2:0] dly_out;

  vga_delay_line #(
    .WIDTH     (3),
    .DEPTH     (FETCH_LAT),
    .RESET_VAL ({~HS_POL, ~VS_POL, 1'b0})
  ) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({hs_c_q, vs_c_q, px_req_q}),
    .q     (dly_out)
  );

  // DAC pin register.
  logic                   hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic [COLOR_DEPTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  always_comb begin
    hs_d      = dly_out[2];
    vs_d      = dly_out[1];
    blank_n_d = dly_out[0];
    r_d       = dly_out[0] ? vga_r_in : '0;
    g_d       = dly_out[0] ? vga_g_in : '0;
    b_d       = dly_out[0] ? vga_b_in : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      blank_n_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign scale_cur   = scale_q;
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign px_req      = px_req_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign vga_r_out   = r_q;
  assign vga_g_out   = g_q;
  assign vga_b_out   = b_q;
  assign vga_blank_n = blank_n_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_sync_n  = 1'b0;
  // DAC samples on the falling pixel-clock edge, mid-way through each pixel.
  assign vga_clk     = ~clk;

endmodule

// File: tb/tb_vga_scaled_driver.sv
// Directed bench for vga_scaled_driver on a reduced 16x8 raster
// (H: 16/2/3/3 = 24 clocks, V: 8/1/2/1 = 12 lines, 288 clocks per frame).
// Three instances with FETCH_LAT 0, 2 and 4 share clock, reset and scale_sel.
// Each colour source returns px_x delayed by its FETCH_LAT, or 8'hFF in ff_mode.
// cyc counts negedges since reset release; cyc = c means the coordinate stage
// is showing raster position c and the pins of a FETCH_LAT=L instance are
// showing position c-(L+1).
module tb_vga_scaled_driver;

  localparam int N = 3;
  localparam int LAT_TAB [N] = '{0, 2, 4};
  localparam int IL0 = 0;
  localparam int M   = 1;
  localparam int IL4 = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ff_mode;
  logic [1:0] scale_sel;

  logic [1:0] scale_cur   [N];
  logic [3:0] px_x        [N];
  logic [2:0] px_y        [N];
  logic       px_req      [N];
  logic       frame_start [N];
  logic       line_start  [N];
  logic [7:0] r_in [N], g_in [N], b_in [N];
  logic [7:0] r_out [N], g_out [N], b_out [N];
  logic       vga_clk [N], blank_n [N], sync_n [N], hs [N], vs [N];

  int vectors     = 0;
  int miscompares = 0;
  int cyc;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [7:0] pipe [1:8];
    logic [7:0] src;

    always @(posedge clk) begin
      pipe[1] <= {4'b0, px_x[g]};
      for (int k = 2; k <= 8; k++) pipe[k] <= pipe[k-1];
    end

    if (LAT_TAB[g] == 0) begin : g_l0
      assign src = {4'b0, px_x[g]};
    end else begin : g_ln
      assign src = pipe[LAT_TAB[g]];
    end

    assign r_in[g] = ff_mode ? 8'hFF : src;
    assign g_in[g] = ff_mode ? 8'hFF : src;
    assign b_in[g] = ff_mode ? 8'hFF : src;

    vga_scaled_driver #(
      .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_ACTIVE(8),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_DEPTH(8), .FETCH_LAT(LAT_TAB[g])
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .scale_sel   (scale_sel),
      .scale_cur   (scale_cur[g]),
      .px_x        (px_x[g]),
      .px_y        (px_y[g]),
      .px_req      (px_req[g]),
      .frame_start (frame_start[g]),
      .line_start  (line_start[g]),
      .vga_r_in    (r_in[g]),
      .vga_g_in    (g_in[g]),
      .vga_b_in    (b_in[g]),
      .vga_r_out   (r_out[g]),
      .vga_g_out   (g_out[g]),
      .vga_b_out   (b_out[g]),
      .vga_clk     (vga_clk[g]),
      .vga_blank_n (blank_n[g]),
      .vga_sync_n  (sync_n[g]),
      .vga_hs      (hs[g]),
      .vga_vs      (vs[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int k, h, v;
    logic act;

    rst_n = 1'b0; scale_sel = 2'd0; ff_mode = 1'b0; cyc = 0;
    repeat (3) @(negedge clk);
    check("rst px_req",      px_req[M], 0);
    check("rst frame_start", frame_start[M], 0);
    check("rst blank_n",     blank_n[M], 0);
    check("rst hs",          hs[M], 1);
    check("rst vs",          vs[M], 1);
    check("rst r",           r_out[M], 0);
    check("rst scale_cur",   scale_cur[M], 0);
    check("sync_n",          sync_n[M], 0);
    check("vga_clk at low clk", vga_clk[M], 1);
    rst_n = 1'b1; cyc = -1;

    // Frame 1, scale 1x.
    step_to(0);
    check("c0 frame_start", frame_start[M], 1);
    check("c0 line_start",  line_start[M], 1);
    check("c0 px_req",      px_req[M], 1);
    check("c0 px_x",        px_x[M], 0);
    check("c0 px_y",        px_y[M], 0);
    check("L0 c0 blank_n",  blank_n[IL0], 0);
    step_to(1);
    check("c1 frame_start", frame_start[M], 0);
    check("c1 line_start",  line_start[M], 0);
    check("c1 px_x",        px_x[M], 1);
    check("L0 first blank_n", blank_n[IL0], 1);
    check("L0 first r",     r_out[IL0], 0);
    step_to(2);  check("L2 c2 blank_n", blank_n[M], 0);
    step_to(3);
    check("L2 first blank_n", blank_n[M], 1);
    check("L2 first r",     r_out[M], 0);
    step_to(4);  check("L4 c4 blank_n", blank_n[IL4], 0);
    step_to(5);
    check("L4 first blank_n", blank_n[IL4], 1);
    check("L4 first r",     r_out[IL4], 0);
    step_to(15); check("c15 px_x", px_x[M], 15);
    step_to(16);
    check("c16 px_req",     px_req[M], 0);
    check("c16 px_x hold",  px_x[M], 15);
    check("L0 last r",      r_out[IL0], 15);
    check("L0 last blank_n", blank_n[IL0], 1);
    step_to(17);
    check("L0 end blank_n", blank_n[IL0], 0);
    check("L0 end r",       r_out[IL0], 0);
    step_to(18);
    check("L2 last r",      r_out[M], 15);
    check("L2 last blank_n", blank_n[M], 1);
    step_to(19);
    check("L2 end blank_n", blank_n[M], 0);
    check("L2 end r",       r_out[M], 0);
    step_to(20);
    check("L2 hs pre",      hs[M], 1);
    check("L4 last r",      r_out[IL4], 15);
    step_to(21);
    check("L2 hs fall",     hs[M], 0);
    check("L4 end blank_n", blank_n[IL4], 0);
    step_to(22); check("L4 hs pre", hs[IL4], 1);
    step_to(23);
    check("L2 hs last",     hs[M], 0);
    check("L4 hs fall",     hs[IL4], 0);
    step_to(24);
    check("L2 hs rise",     hs[M], 1);
    check("c24 line_start", line_start[M], 1);
    check("c24 px_y",       px_y[M], 1);
    check("c24 px_x",       px_x[M], 0);
    step_to(25); check("L4 hs last", hs[IL4], 0);
    step_to(26); check("L4 hs rise", hs[IL4], 1);
    step_to(45); check("line2 hs low",  hs[M], 0);
    step_to(48); check("line2 hs high", hs[M], 1);
    step_to(100); scale_sel = 2'd1;
    step_to(168); check("c168 px_y", px_y[M], 7);
    step_to(192);
    check("c192 px_req",    px_req[M], 0);
    check("c192 px_y hold", px_y[M], 7);
    step_to(200); check("mid-frame scale_cur", scale_cur[M], 0);
    step_to(218); check("vs pre",  vs[M], 1);
    step_to(219); check("vs fall", vs[M], 0);
    step_to(266); check("vs last", vs[M], 0);
    step_to(267); check("vs rise", vs[M], 1);
    step_to(286); check("pre-wrap scale_cur",  scale_cur[M], 0);
    step_to(287); check("wrap edge scale_cur", scale_cur[M], 1);

    // Frame 2, scale 2x.
    step_to(288);
    check("f2 frame_start", frame_start[M], 1);
    check("f2 px_x0",       px_x[M], 0);
    check("f2 px_y0",       px_y[M], 0);
    step_to(289); check("2x px_x h1",  px_x[M], 0);
    step_to(290); check("2x px_x h2",  px_x[M], 1);
    step_to(303); check("2x px_x h15", px_x[M], 7);
    step_to(304); check("2x px_x hold", px_x[M], 7);
    step_to(312);
    check("2x line1 line_start", line_start[M], 1);
    check("2x px_y v1", px_y[M], 0);
    step_to(336); check("2x px_y v2", px_y[M], 1);
    step_to(400); scale_sel = 2'd3;
    step_to(456); check("2x px_y v7", px_y[M], 3);
    step_to(574); check("f2 end scale_cur", scale_cur[M], 1);
    step_to(575); check("reserved -> 1x",   scale_cur[M], 0);

    // Frame 3, reserved select behaves as 1x.
    step_to(576); check("f3 frame_start", frame_start[M], 1);
    step_to(577); check("f3 px_x h1", px_x[M], 1);
    step_to(578); check("f3 px_x h2", px_x[M], 2);
    step_to(600); check("f3 px_y v1", px_y[M], 1);
    step_to(700); scale_sel = 2'd2;
    step_to(862); check("f3 end scale_cur", scale_cur[M], 0);
    step_to(863); check("4x scale_cur",     scale_cur[M], 2);

    // Frame 4, scale 4x, colour sources forced to 8'hFF.
    step_to(864);
    check("f4 frame_start", frame_start[M], 1);
    check("f4 px_x0",       px_x[M], 0);
    ff_mode = 1'b1;
    step_to(867); check("4x px_x h3",  px_x[M], 0);
    step_to(868); check("4x px_x h4",  px_x[M], 1);
    step_to(879); check("4x px_x h15", px_x[M], 3);
    for (int c = 880; c <= 1151; c++) begin
      step_to(c);
      k = c - 867;
      h = k % 24;
      v = k / 24;
      act = (h < 16) && (v < 8);
      check("ff blank_n", blank_n[M], act);
      check("ff r", r_out[M], act ? 8'hFF : 8'h00);
      check("ff g", g_out[M], act ? 8'hFF : 8'h00);
      check("ff b", b_out[M], act ? 8'hFF : 8'h00);
      if (c == 960) check("4x px_y v4", px_y[M], 1);
    end
    ff_mode = 1'b0;

    // Frame 5 (4x), reset applied at h=11, v=3.
    step_to(1235);
    check("pre-rst blank_n",   blank_n[M], 1);
    check("pre-rst r",         r_out[M], 2);
    check("pre-rst scale_cur", scale_cur[M], 2);
    rst_n = 1'b0;
    #1;
    check("async rst blank_n",   blank_n[M], 0);
    check("async rst r",         r_out[M], 0);
    check("async rst px_req",    px_req[M], 0);
    check("async rst scale_cur", scale_cur[M], 0);
    check("async rst hs",        hs[M], 1);
    check("async rst vs",        vs[M], 1);
    check("async rst L0 blank_n", blank_n[IL0], 0);
    @(negedge clk);
    @(negedge clk);
    scale_sel = 2'd1;
    rst_n = 1'b1; cyc = -1;
    step_to(0);
    check("rel frame_start", frame_start[M], 1);
    check("rel px_x",        px_x[M], 0);
    step_to(2);
    check("rel px_x 1x",     px_x[M], 2);
    check("rel scale_cur",   scale_cur[M], 0);
    step_to(20); check("rel hs pre",  hs[M], 1);
    step_to(21); check("rel hs fall", hs[M], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
